// File: rtl/updata_pkg.sv
// Shared definitions for the station-upload link (transmitter and receiver).
// Latency: n/a (types, constants and a byte-packing helper only).
// Backpressure: n/a.
package updata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_COUNT,
    ST_LOC,
    ST_WAIT_CMP
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h00;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  // Location byte layout: line number in the high nibble, station in the low nibble.
  localparam int LINE_HI = 7;
  localparam int LINE_LO = 4;
  localparam int STN_HI  = 3;
  localparam int STN_LO  = 0;

  function automatic logic [7:0] loc_byte(input logic [3:0] line, input logic [3:0] stn);
    logic [7:0] b;
    b = '0;
    b[LINE_HI:LINE_LO] = line;
    b[STN_HI:STN_LO]   = stn;
    return b;
  endfunction

endpackage

// File: rtl/updata_tx_if.sv
// Upload link bus between updata_tx (master) and the updata receiver (slave).
// Latency: n/a (wires only).
// Backpressure: none; the receiver reports completion through rx_cmp8.
// Signals: out_RDY8 frame-valid, DATA_out8 frame byte, rx_cmp8 receiver completion.
interface updata_tx_if;
  logic       out_RDY8;
  logic [7:0] DATA_out8;
  logic       rx_cmp8;

  modport master (output out_RDY8, output DATA_out8, input rx_cmp8);
  modport slave  (input out_RDY8, input DATA_out8, output rx_cmp8);
endinterface

// File: rtl/updata_tx_table.sv
// Station location table: MAX_STATIONS x 8 registers, gated write, async read.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: writes with wr_allow low are dropped silently.
// Ports: clk/rst, we+wr_allow+waddr+wdata write side, raddr/rdata read side.
module updata_tx_table #(
  parameter int MAX_STATIONS = 16,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wr_allow,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MAX_STATIONS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_STATIONS; i++) mem_q[i] <= 8'h00;
    end else if (we && wr_allow) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/updata_tx.sv
// Upload transmitter: streams sync, count and table bytes, then waits for rx_cmp8.
// Latency: sync byte after E+1 for start sampled at E; count E+2; location k at E+3+k.
// Backpressure: none on the bus; start is only sampled in IDLE, table writes only in IDLE.
// Ports: clk/rst, load_* table writes, num_stations/start, bus (master), busy/done/err status.
module updata_tx
  import updata_pkg::*;
#(
  parameter int MAX_STATIONS = 16,
  parameter int AW           = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [7:0]    num_stations,
  input  logic          start,
  updata_tx_if.master   bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;     // one extra bit so a full table does not wrap
  logic [TW-1:0] timer_q, timer_d;
  logic          rej_q, rej_d;     // reject pending: err goes out one cycle later
  logic          rdy_d, busy_d, done_d, err_d;
  logic [7:0]    dat_d;
  logic [7:0]    tbl_rd;
  logic          too_many, last_loc, timer_hit;

  updata_tx_table #(.MAX_STATIONS(MAX_STATIONS), .AW(AW)) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (load_we),
    .wr_allow(state_q == ST_IDLE),
    .waddr   (load_addr),
    .wdata   (load_data),
    .raddr   (idx_q[AW-1:0]),
    .rdata   (tbl_rd)
  );

  assign too_many  = {1'b0, num_stations} > 9'(MAX_STATIONS);
  assign last_loc  = ({1'b0, cnt_q} == (9'(idx_q) + 9'd1));
  assign timer_hit = (timer_q == TW'(TIMEOUT - 1));

  // Frame outputs are registered from the current state, so each byte lands
  // one cycle after the state that produces it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rej_d   = 1'b0;
    rdy_d   = 1'b0;
    dat_d   = IDLE_BYTE;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = rej_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !rej_q) begin
          cnt_d = num_stations;
          if (too_many) rej_d = 1'b1;
          else          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        rdy_d   = 1'b1;
        dat_d   = SYNC_BYTE;
        busy_d  = 1'b1;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        rdy_d   = 1'b1;
        dat_d   = cnt_q;
        busy_d  = 1'b1;
        idx_d   = '0;
        timer_d = '0;
        state_d = (cnt_q == 8'd0) ? ST_WAIT_CMP : ST_LOC;
      end
      ST_LOC: begin
        rdy_d   = 1'b1;
        dat_d   = tbl_rd;
        busy_d  = 1'b1;
        idx_d   = idx_q + (AW+1)'(1);
        timer_d = '0;
        if (last_loc) state_d = ST_WAIT_CMP;
      end
      ST_WAIT_CMP: begin
        // Completion beats a timeout landing in the same cycle.
        if (bus.rx_cmp8) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      rej_q         <= 1'b0;
      bus.out_RDY8  <= 1'b0;
      bus.DATA_out8 <= IDLE_BYTE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      rej_q         <= rej_d;
      bus.out_RDY8  <= rdy_d;
      bus.DATA_out8 <= dat_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_updata_tx.sv
// Self-checking bench for updata_tx: directed steps plus randomized frames
// checked against a table-array / byte-queue reference model.
module tb_updata_tx;
  import updata_pkg::*;

  localparam int MAXS = 16;
  localparam int AW   = 4;
  localparam int TO   = 32;

  logic          clk;
  logic          rst;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic [7:0]    num_stations;
  logic          start;
  logic          busy, done, err;

  updata_tx_if bus();

  updata_tx #(.MAX_STATIONS(MAXS), .AW(AW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .num_stations(num_stations),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mtab [MAXS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic [7:0] dat,
                          input logic bsy, input logic dn, input logic er);
    chk({tag, " out_RDY8"}, 32'(bus.out_RDY8), 32'(rdy));
    chk({tag, " DATA_out8"}, 32'(bus.DATA_out8), 32'(dat));
    chk({tag, " busy"}, 32'(busy), 32'(bsy));
    chk({tag, " done"}, 32'(done), 32'(dn));
    chk({tag, " err"}, 32'(err), 32'(er));
  endtask

  task automatic load(input int a, input logic [7:0] d);
    load_we   = 1'b1;
    load_addr = a[AW-1:0];
    load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    mtab[a] = d;
  endtask

  // One complete frame. rx_at: wait cycle (1..TO) where rx_cmp8 is raised,
  // 0 for never. hold keeps start high throughout; disturb fires a table write,
  // a start and a stray rx_cmp8 during the location bytes (all to be ignored).
  task automatic frame(input int n, input int rx_at, input bit hold, input bit disturb);
    logic [7:0] expq[$];
    num_stations = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start   = hold;
    load_we = 1'b0;
    chk_outs($sformatf("n=%0d launch", n), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    expq = {};
    expq.push_back(SYNC_BYTE);
    expq.push_back(8'(n));
    for (int k = 0; k < n; k++) expq.push_back(mtab[k]);
    for (int i = 0; i < n + 2; i++) begin
      if (disturb && i == 2) begin
        load_we = 1'b1; load_addr = '0; load_data = 8'hFF; start = 1'b1; bus.rx_cmp8 = 1'b1;
      end
      @(negedge clk);
      load_we = 1'b0; start = hold; bus.rx_cmp8 = 1'b0;
      chk_outs($sformatf("n=%0d byte%0d", n, i), 1'b1, expq[i], 1'b1, 1'b0, 1'b0);
    end
    for (int w = 1; w <= TO; w++) begin
      bus.rx_cmp8 = (w == rx_at);
      @(negedge clk);
      if (w == rx_at) begin
        chk_outs($sformatf("n=%0d done@%0d", n, w), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        break;
      end else if (w == TO) begin
        chk_outs($sformatf("n=%0d timeout", n), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      end else begin
        chk_outs($sformatf("n=%0d wait%0d", n, w), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
    end
    bus.rx_cmp8 = 1'b0;
  endtask

  initial begin
    int n, rx;
    rst = 1'b1;
    load_we = 1'b0; load_addr = '0; load_data = 8'h00;
    num_stations = 8'h00; start = 1'b0; bus.rx_cmp8 = 1'b0;
    foreach (mtab[k]) mtab[k] = 8'h00;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Basic three-station frame, completion two cycles into the wait.
    load(0, 8'h22); load(1, 8'h13); load(2, 8'h31);
    frame(3, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("after done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Empty frame, receiver never completes.
    frame(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("after timeout", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Over-long count is rejected without a frame.
    num_stations = 8'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_outs("reject launch", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("reject err", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_outs("reject quiet", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Full table, every entry in address order.
    for (int a = 0; a < MAXS; a++) load(a, loc_byte(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
    frame(MAXS, 5, 1'b0, 1'b0);

    // Writes, start and rx_cmp8 during the frame are ignored; an idle write shows next time.
    frame(4, 3, 1'b0, 1'b1);
    load(0, 8'hFF);
    load_we = 1'b1; load_addr = 4'd1; load_data = 8'h5A; mtab[1] = 8'h5A;  // same cycle as start
    frame(2, 1, 1'b0, 1'b0);

    // Completion arriving on the last timeout cycle wins.
    frame(1, TO, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("after late done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // start held high: the next frame begins right after done.
    frame(2, 1, 1'b1, 1'b0);
    frame(3, 2, 1'b0, 1'b0);

    // Reset while location 1 is being fetched.
    num_stations = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("pre-reset loc0", 1'b1, mtab[0], 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_outs("async reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("in reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    foreach (mtab[k]) mtab[k] = 8'h00;
    @(negedge clk);
    chk_outs("post reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    frame(3, 1, 1'b0, 1'b0);

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 3))
        load($urandom_range(0, MAXS - 1), loc_byte(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
      n  = $urandom_range(0, MAXS);
      rx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TO);
      frame(n, rx, 1'b0, 1'b0);
      @(negedge clk);
      chk_outs($sformatf("rand%0d idle", r), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
